// File: rtl/add_serial_pkg.sv
`default_nettype none
// =============================================================================
// add_serial_pkg : sequencer states and counter sizing for add_serial_seq
// Rev 1.0
// =============================================================================
package add_serial_pkg;

  localparam int c_DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RESULT  = 3'd4
  } state_t;

  // Bits needed to count 0..n-1, never fewer than one.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/add_serial_seq.sv
`default_nettype none
// =============================================================================
// add_serial_seq : operand sequencer / result collector for the bit-serial adder
// Optional carry-out port enabled by `define ADD_SERIAL_SEQ_OVF_EN
// Rev 1.0
// =============================================================================
module add_serial_seq
  import add_serial_pkg::*;
#(
  parameter int WIDTH      = c_DEFAULT_WIDTH,
  parameter int ADD_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_en,
  input  logic [WIDTH-1:0] add_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             busy
`ifdef ADD_SERIAL_SEQ_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int                 c_CNT_W    = clog2(ADD_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ADD_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_add_a;
  logic [WIDTH-1:0]   r_add_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_add_en;
  logic               w_en_nxt;
  logic               w_accept;

  assign w_accept = (r_state == ST_IDLE) && in_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (in_valid) w_state_nxt = ST_LAUNCH;
      ST_LAUNCH:  w_state_nxt = ST_WAIT;
      ST_WAIT:    if (r_cnt == c_CNT_LAST) w_state_nxt = ST_RELEASE;
      ST_RELEASE: w_state_nxt = ST_RESULT;
      ST_RESULT:  if (out_ready) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // en is registered from the next state so the pulse lines up with LAUNCH/RELEASE;
  // those states are always followed by WAIT/RESULT, so en can never repeat.
  assign w_en_nxt = (w_state_nxt == ST_LAUNCH) || (w_state_nxt == ST_RELEASE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_add_en <= 1'b0;
      r_add_a  <= '0;
      r_add_b  <= '0;
      r_cnt    <= '0;
      r_sum    <= '0;
    end else begin
      r_add_en <= w_en_nxt;
      if (w_accept) begin
        r_add_a <= in_a;
        r_add_b <= in_b;
      end
      if (r_state == ST_LAUNCH) begin
        r_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
      if (r_state == ST_RELEASE) begin
        r_sum <= add_out;
      end
    end
  end

`ifdef ADD_SERIAL_SEQ_OVF_EN
  logic r_ovf;

  // Carry-out rebuilt from the operand MSBs and the sum MSB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == ST_RELEASE) begin
      r_ovf <= (r_add_a[WIDTH-1] & r_add_b[WIDTH-1]) |
               ((r_add_a[WIDTH-1] | r_add_b[WIDTH-1]) & ~add_out[WIDTH-1]);
    end
  end

  assign out_ovf = r_ovf;
`endif

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = (r_state == ST_RESULT);
  assign add_en    = r_add_en;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign out_sum   = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_add_serial_seq.sv
`default_nettype none
// =============================================================================
// tb_add_serial_seq : self-checking bench for add_serial_seq with a stand-in adder
// Rev 1.0
// =============================================================================
module tb_add_serial_seq;

  localparam int W  = 8;
  localparam int AC = W;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_en;
  logic [W-1:0] add_out;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         busy;
`ifdef ADD_SERIAL_SEQ_OVF_EN
  logic         out_ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_en_dbl = 0;

  add_serial_seq #(.WIDTH(W), .ADD_CYCLES(AC)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_en   (add_en),
    .add_out  (add_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .busy     (busy)
`ifdef ADD_SERIAL_SEQ_OVF_EN
    ,
    .out_ovf  (out_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in serial adder: loads on en from IDLE, spends AC cycles adding,
  // shows the sum only in DONE, and returns to IDLE on the next en.
  int           m_st;
  int           m_k;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  logic [W-1:0] m_sum;
  assign m_sum   = m_a + m_b;
  assign add_out = (m_st == 2) ? m_sum : ~m_sum;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_st <= 0;
      m_k  <= 0;
      m_a  <= '0;
      m_b  <= '0;
    end else begin
      case (m_st)
        0: if (add_en) begin m_st <= 1; m_k <= 0; m_a <= add_a; m_b <= add_b; end
        1: begin if (m_k == AC - 1) m_st <= 2; m_k <= m_k + 1; end
        default: if (add_en) m_st <= 0;
      endcase
    end
  end

  logic en_prev = 1'b0;
  always @(negedge clk) begin
    if (add_en && en_prev) n_en_dbl++;
    en_prev <= add_en;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, watch en pulses and latency, hold the result
  // for rdy_dly cycles, then complete the output handshake.
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int rdy_dly,
                         input int inject, input logic [W-1:0] exp_sum, input logic exp_ovf,
                         input string tag);
    int          n;
    logic [63:0] mask;
    logic [63:0] exp_mask;
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) begin
      check({tag, "_accept_timeout"}, 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0; in_a = ~a; in_b = ~b;
    check({tag, "_add_a"}, 32'(add_a), 32'(a));
    check({tag, "_add_b"}, 32'(add_b), 32'(b));
    mask = '0;
    n = 0;
    while (!out_valid && n < 40) begin
      if (add_en) mask[n] = 1'b1;
      if (inject != 0 && n == inject) begin
        check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_a = 8'hAA; in_b = 8'h55;
      end
      tick();
      in_valid = 1'b0;
      n++;
    end
    exp_mask = '0;
    exp_mask[0] = 1'b1;
    exp_mask[AC+1] = 1'b1;
    check({tag, "_latency"}, 32'(n), 32'(AC + 2));
    check({tag, "_en_pulses"}, mask[31:0], exp_mask[31:0]);
    check({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
    check({tag, "_add_a_hold"}, 32'(add_a), 32'(a));
`ifdef ADD_SERIAL_SEQ_OVF_EN
    check({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("note: ovf expectation unknown for %s", tag);
`endif
    for (int i = 0; i < rdy_dly; i++) begin
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_sum"}, 32'(out_sum), 32'(exp_sum));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      tick();
    end
    check({tag, "_busy_result"}, 32'(busy), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           rdy;
    logic [W-1:0] exp_sum;
    logic         exp_ovf;
  } vec_t;

  initial begin
    vec_t        vecs[6];
    logic [W:0]  full;
    int          acc_t[2];
    logic [W-1:0] sums[2];
    int          n_acc;
    int          n_res;
    int          t;
    logic        acc;
    logic        hs;

    vecs[0] = '{8'd5,   8'd3,   0, 8'd8,   1'b0};
    vecs[1] = '{8'd200, 8'd100, 0, 8'd44,  1'b1};
    vecs[2] = '{8'd255, 8'd1,   6, 8'd0,   1'b1};
    vecs[3] = '{8'd0,   8'd0,   1, 8'd0,   1'b0};
    vecs[4] = '{8'd128, 8'd128, 2, 8'd0,   1'b1};
    vecs[5] = '{8'd127, 8'd1,   0, 8'd128, 1'b0};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_add_en", 32'(add_en), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_add_b", 32'(add_b), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    tick();

    foreach (vecs[i]) run_txn(vecs[i].a, vecs[i].b, vecs[i].rdy, 0,
                              vecs[i].exp_sum, vecs[i].exp_ovf, $sformatf("vec%0d", i));

    // Operands presented while busy must not be latched.
    run_txn(8'd3, 8'd4, 0, 4, 8'd7, 1'b0, "inject");

    // Back-to-back with in_valid held and out_ready tied high.
    in_a = 8'd1; in_b = 8'd2; in_valid = 1'b1; out_ready = 1'b1;
    n_acc = 0; n_res = 0; t = 0;
    while (n_res < 2 && t < 60) begin
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs) sums[n_res] = out_sum;
      tick();
      t++;
      if (hs) n_res++;
      if (acc) begin
        acc_t[n_acc] = t;
        n_acc++;
        if (n_acc == 1) begin in_a = 8'd7; in_b = 8'd9; end
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b0; in_valid = 1'b0;
    check("b2b_results", 32'(n_res), 32'd2);
    check("b2b_spacing", 32'(acc_t[1] - acc_t[0]), 32'(AC + 4));
    check("b2b_sum0", 32'(sums[0]), 32'd3);
    check("b2b_sum1", 32'(sums[1]), 32'd16);

    // Asynchronous reset in the middle of WAIT.
    in_a = 8'd50; in_b = 8'd60; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #3;
    rst = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_add_en", 32'(add_en), 32'd0);
    check("arst_add_a", 32'(add_a), 32'd0);
    check("arst_add_b", 32'(add_b), 32'd0);
    check("arst_out_sum", 32'(out_sum), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < AC + 4; i++) begin
      if (out_valid) check("arst_no_result", 32'(out_valid), 32'd0);
      tick();
    end
    run_txn(8'd10, 8'd20, 0, 0, 8'd30, 1'b0, "post_rst");

    // Random pairs against plain modular arithmetic.
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      full = {1'b0, ra} + {1'b0, rb};
      run_txn(ra, rb, int'($urandom_range(0, 3)), 0, full[W-1:0], full[W],
              $sformatf("rnd%0d", i));
    end

    check("en_never_consecutive", 32'(n_en_dbl), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
